bin2bcd_seq: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter (iterative double-dabble) with a valid/ready handshake on both sides.

---
 rtl/bin2bcd_seq.sv | 190 +++++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Iterative double-dabble binary-to-BCD converter with a
//                valid/ready handshake on input and output. Supports two's
//                complement input (magnitude converted, sign reported), a raw
//                hex-nibble mode, detection of dropped nonzero digits, and
//                active-low gfedcba seven-segment encoding per digit.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready, bin_in[BIN_W], hex_mode  - request side
//                out_valid/out_ready, bcd_out[4*DIGITS],
//                neg_out, overflow, seg_out[7*DIGITS]        - result side
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  hex_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg_out,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg_out
);

  // ceil(BIN_W*log10(2)) + 1 digits, using 0.30103 as log10(2)
  localparam int DINT  = (BIN_W * 30103 + 99999) / 100000 + 1;
  // Scratch must also be wide enough to present DIGITS digits
  localparam int SW    = (DINT > DIGITS) ? DINT : DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic                in_ready_q,  in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [4*SW-1:0]     scratch_q,   scratch_d;
  logic [BIN_W-1:0]    mag_q,       mag_d;
  logic                neg_q,       neg_d;
  logic [4*DIGITS-1:0] bcd_q,       bcd_d;
  logic                neg_out_q,   neg_out_d;
  logic                overflow_q,  overflow_d;

  logic [4*SW-1:0]     adj;
  logic [BIN_W-1:0]    bin_neg;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    scratch_d   = scratch_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    bcd_d       = bcd_q;
    neg_out_d   = neg_out_q;
    overflow_d  = overflow_q;

    // Add-3 correction applied to every digit before the shift
    adj = scratch_q;
    for (int k = 0; k < SW; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end

    // Two's complement negate; the most negative value wraps to its
    // correct unsigned magnitude (e.g. 8'h80 -> 128)
    bin_neg = -bin_in;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_W);
          if (hex_mode) begin
            scratch_d[BIN_W-1:0] = bin_in;
            neg_d                = 1'b0;
            state_d              = DONE;
          end else if ((SIGNED != 0) && bin_in[BIN_W-1]) begin
            mag_d   = bin_neg;
            neg_d   = 1'b1;
            state_d = SHIFT;
          end else begin
            mag_d   = bin_in;
            neg_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        {scratch_d, mag_d} = {adj, mag_q} << 1;
        cnt_d              = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle publishes the result; it is then held until taken
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          bcd_d       = scratch_q[4*DIGITS-1:0];
          overflow_d  = (scratch_q >> (4 * DIGITS)) != '0;
          neg_out_d   = neg_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      scratch_q   <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      bcd_q       <= '0;
      neg_out_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      scratch_q   <= scratch_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      bcd_q       <= bcd_d;
      neg_out_q   <= neg_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign neg_out   = neg_out_q;
  assign overflow  = overflow_q;

  // Active-low segments, bit order gfedcba
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    assign seg_out[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
  end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Self-checking bench for bin2bcd_seq. Four instances share one
//                stimulus stream: unsigned 3-digit, signed 3-digit, unsigned
//                2-digit and unsigned 1-digit. Expected results are queued at
//                drive time and compared when the results come out.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, hex_mode, out_ready;
  logic [7:0] bin_in;

  logic        in_ready0, in_ready1, in_ready2, in_ready3;
  logic        out_valid0, out_valid1, out_valid2, out_valid3;
  logic [11:0] bcd0, bcd1;
  logic [7:0]  bcd2;
  logic [3:0]  bcd3;
  logic        neg0, neg1, neg2, neg3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic [20:0] seg0, seg1;
  logic [13:0] seg2;
  logic [6:0]  seg3;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .bin_in(bin_in), .hex_mode(hex_mode), .out_valid(out_valid0),
    .out_ready(out_ready), .bcd_out(bcd0), .neg_out(neg0),
    .overflow(ovf0), .seg_out(seg0));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .bin_in(bin_in), .hex_mode(hex_mode), .out_valid(out_valid1),
    .out_ready(out_ready), .bcd_out(bcd1), .neg_out(neg1),
    .overflow(ovf1), .seg_out(seg1));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .bin_in(bin_in), .hex_mode(hex_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .bcd_out(bcd2), .neg_out(neg2),
    .overflow(ovf2), .seg_out(seg2));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(1), .SIGNED(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .bin_in(bin_in), .hex_mode(hex_mode), .out_valid(out_valid3),
    .out_ready(out_ready), .bcd_out(bcd3), .neg_out(neg3),
    .overflow(ovf3), .seg_out(seg3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [11:0] b0; logic o0;
    logic [11:0] b1; logic n1; logic o1;
    logic [7:0]  b2; logic o2;
    logic [3:0]  b3; logic o3;
  } exp_t;

  exp_t q[$];

  // Digit extraction by repeated division, base 10 or 16
  function automatic void conv(input int val, input int base, input int nd,
                               output logic [39:0] b, output logic o);
    int v;
    int d;
    v = val;
    b = '0;
    o = 1'b0;
    for (int k = 0; k < 10; k++) begin
      d = v % base;
      if (k < nd) b[4*k +: 4] = 4'(d);
      else if (d != 0) o = 1'b1;
      v = v / base;
    end
  endfunction

  function automatic exp_t model(input logic [7:0] v, input logic h);
    exp_t        e;
    logic [39:0] b;
    logic        o;
    int          base;
    int          mag;
    base = h ? 16 : 10;
    conv(int'(v), base, 3, b, o); e.b0 = b[11:0]; e.o0 = o;
    conv(int'(v), base, 2, b, o); e.b2 = b[7:0];  e.o2 = o;
    conv(int'(v), base, 1, b, o); e.b3 = b[3:0];  e.o3 = o;
    e.n1 = !h && v[7];
    mag  = e.n1 ? 256 - int'(v) : int'(v);
    conv(mag, base, 3, b, o); e.b1 = b[11:0]; e.o1 = o;
    return e;
  endfunction

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  // Result monitor: pops the scoreboard on every completed handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid0 && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_valid", 40'(out_valid0), 40'(0));
      end else begin
        e = q.pop_front();
        check("valid_all", 40'({out_valid1, out_valid2, out_valid3}), 40'(3'b111));
        check("d3_bcd",  40'(bcd0), 40'(e.b0));
        check("d3_ovf",  40'(ovf0), 40'(e.o0));
        check("d3_neg",  40'(neg0), 40'(0));
        check("s3_bcd",  40'(bcd1), 40'(e.b1));
        check("s3_neg",  40'(neg1), 40'(e.n1));
        check("s3_ovf",  40'(ovf1), 40'(e.o1));
        check("d2_bcd",  40'(bcd2), 40'(e.b2));
        check("d2_ovf",  40'(ovf2), 40'(e.o2));
        check("d1_bcd",  40'(bcd3), 40'(e.b3));
        check("d1_ovf",  40'(ovf3), 40'(e.o3));
        for (int k = 0; k < 3; k++) begin
          check("d3_seg", 40'(seg0[7*k +: 7]), 40'(seg_ref(e.b0[4*k +: 4])));
        end
      end
    end
  end

  task automatic send(input logic [7:0] v, input logic h);
    int n;
    n = 0;
    while (!in_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) check("ready_timeout", 40'(in_ready0), 40'(1));
    in_valid = 1'b1;
    bin_in   = v;
    hex_mode = h;
    q.push_back(model(v, h));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts clocks from the accept edge until out_valid is seen
  task automatic wait_valid(output int k);
    k = 1;
    while (!out_valid0 && k < 40) begin
      @(negedge clk);
      if (!out_valid0) k++;
    end
    if (!out_valid0) check("valid_timeout", 40'(out_valid0), 40'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 40'(q.size()), 40'(0));
  endtask

  typedef struct {
    logic [7:0] v; logic [11:0] b0; logic [11:0] b1; logic n1; logic [7:0] b2; logic o2;
  } spot_t;

  spot_t spots [6];
  int    lat;

  initial begin
    spots[0] = '{8'd0,   12'h000, 12'h000, 1'b0, 8'h00, 1'b0};
    spots[1] = '{8'd99,  12'h099, 12'h099, 1'b0, 8'h99, 1'b0};
    spots[2] = '{8'd100, 12'h100, 12'h100, 1'b0, 8'h00, 1'b1};
    spots[3] = '{8'd200, 12'h200, 12'h056, 1'b1, 8'h00, 1'b1};
    spots[4] = '{8'h80,  12'h128, 12'h128, 1'b1, 8'h28, 1'b1};
    spots[5] = '{8'h7F,  12'h127, 12'h127, 1'b0, 8'h27, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; bin_in = '0; hex_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 40'(in_ready0), 40'(0));
    check("rst_valid", 40'(out_valid0), 40'(0));
    check("rst_bcd",   40'(bcd0), 40'(0));
    check("rst_ovf",   40'(ovf0), 40'(0));
    check("rst_neg",   40'(neg1), 40'(0));
    check("rst_seg",   40'(seg0), 40'({3{7'b1000000}}));
    rst_n = 1'b1;
    @(negedge clk);

    // 8'hFF: decimal latency and literal result
    send(8'hFF, 1'b0);
    wait_valid(lat);
    check("lat_dec", 40'(lat), 40'(9));
    check("ff_bcd",  40'(bcd0), 40'(12'h255));
    check("ff_sbcd", 40'(bcd1), 40'(12'h001));
    check("ff_sneg", 40'(neg1), 40'(1));
    drain();

    // Hex mode: latency, nibbles, segments, 1-digit overflow
    send(8'hAB, 1'b1);
    wait_valid(lat);
    check("lat_hex",  40'(lat), 40'(1));
    check("hex_bcd",  40'(bcd0), 40'(12'h0AB));
    check("hex_seg0", 40'(seg0[6:0]),  40'(7'b0000011));
    check("hex_seg1", 40'(seg0[13:7]), 40'(7'b0001000));
    check("hex_d1",   40'(bcd3), 40'(4'hB));
    check("hex_d1o",  40'(ovf3), 40'(1));
    check("hex_sneg", 40'(neg1), 40'(0));
    drain();

    foreach (spots[i]) begin
      send(spots[i].v, 1'b0);
      wait_valid(lat);
      check("spot_d3",  40'(bcd0), 40'(spots[i].b0));
      check("spot_s3",  40'(bcd1), 40'(spots[i].b1));
      check("spot_sn",  40'(neg1), 40'(spots[i].n1));
      check("spot_d2",  40'(bcd2), 40'(spots[i].b2));
      check("spot_d2o", 40'(ovf2), 40'(spots[i].o2));
      drain();
    end

    for (int v = 0; v < 256; v++) send(8'(v), 1'b0);
    drain();
    for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)), 1'b1);
    drain();

    // Backpressure: result held, busy input ignored
    out_ready = 1'b0;
    send(8'd200, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      bin_in   = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("bp_valid", 40'(out_valid0), 40'(1));
      check("bp_ready", 40'(in_ready0), 40'(0));
      check("bp_bcd",   40'(bcd0), 40'(12'h200));
      check("bp_d2o",   40'(ovf2), 40'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);

    // Reset mid-conversion
    send(8'd255, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 40'(out_valid0), 40'(0));
    check("mid_rst_ready", 40'(in_ready0), 40'(0));
    check("mid_rst_bcd",   40'(bcd0), 40'(0));
    check("mid_rst_ovf",   40'(ovf2), 40'(0));
    check("mid_rst_seg",   40'(seg0), 40'({3{7'b1000000}}));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 40'(in_ready0), 40'(1));
    check("post_rst_valid", 40'(out_valid0), 40'(0));
    repeat (15) @(negedge clk);

    send(8'd42, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
